// File: rtl/bus_oe_arbiter.sv
// bus_oe_arbiter: round-robin owner of a shared 4-bit tristate bus driving 74173 m / g1_n pins
// clk      : clock, all state changes on posedge
// clr_n    : asynchronous active-low reset
// req      : per-bank bus request, level
// ld_req   : per-bank load request, sampled every cycle
// oe_n     : per-bank active-low output enable (74173 m)
// ld_n     : per-bank active-low load strobe (74173 g1_n), one cycle after ld_req
// grant    : one-hot current owner, always ~oe_n
// bus_busy : high while a grant or turnaround is in progress
module bus_oe_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int MIN_HOLD   = 2,
   parameter int MAX_GRANT  = 16,
   parameter int TURNAROUND = 1
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] ld_req,
   output logic [NUM_REQ-1:0] oe_n,
   output logic [NUM_REQ-1:0] ld_n,
   output logic [NUM_REQ-1:0] grant,
   output logic               bus_busy
);
   // grant counter must reach MIN_HOLD even when preemption is disabled
   localparam int GMAX = MIN_HOLD > MAX_GRANT ? MIN_HOLD : MAX_GRANT;
   localparam int CMAX = GMAX > TURNAROUND ? GMAX : TURNAROUND;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int RW   = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
   state_t        state;
   logic [RW-1:0] rr, win;
   logic [CW-1:0] cnt;
   logic          rel;
   // lowest-distance requester above rr wins: scan from farthest to nearest so the nearest overwrites
   always_comb begin
      win = rr;
      for (int i = NUM_REQ; i >= 1; i--)
         if (req[(int'(rr) + i) % NUM_REQ]) win = RW'((int'(rr) + i) % NUM_REQ);
   end
   assign rel = (!(|(req & grant)) && cnt >= CW'(MIN_HOLD)) ||
                (MAX_GRANT != 0 && cnt == CW'(MAX_GRANT) && |(req & ~grant));
   assign oe_n     = ~grant;
   assign bus_busy = state != IDLE;
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= IDLE;
         rr    <= RW'(NUM_REQ - 1);
         cnt   <= '0;
         grant <= '0;
         ld_n  <= '1;
      end else begin
         ld_n <= ~ld_req;
         case (state)
            IDLE:
               if (|req) begin
                  grant <= NUM_REQ'(1) << win;
                  rr    <= win;
                  cnt   <= CW'(1);
                  state <= GRANT;
               end
            GRANT:
               if (rel) begin
                  grant <= '0;
                  cnt   <= CW'(1);
                  state <= TURN;
               end else if (cnt < CW'(GMAX)) cnt <= cnt + 1'b1;
            TURN:
               if (cnt >= CW'(TURNAROUND)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/bus_oe_arbiter.md
Name: bus_oe_arbiter

Overview:
- Round-robin arbiter sharing one 4-bit tristate data bus among NUM_REQ 74173-style register banks.
- Drives each bank's output-enable (m input; n tied low at top level) so at most one bank drives the bus at any time.
- Inserts a guaranteed idle turnaround between owners.
- Sequences per-bank load strobes (g1_n input; g2_n tied low at top level) as registered single-cycle pulses.
- Sits between the terminal control logic and the register banks.

Parameters:
- NUM_REQ, 4, number of register banks / requesters (2..8).
- MIN_HOLD, 2, minimum grant length in cycles before release is honoured (>=1).
- MAX_GRANT, 16, grant cycles after which the owner is preempted if another request is pending; 0 = never preempt.
- TURNAROUND, 1, bus-idle cycles between grants (>=1).

Ports:
- clk  input  1  clock; all state changes on posedge.
- clr_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-bank bus request, level; held high while bank wants the bus.
- ld_req  input  NUM_REQ  per-bank load request, sampled each cycle.
- oe_n  output  NUM_REQ  per-bank output enable to 74173 m pin, active-low, registered.
- ld_n  output  NUM_REQ  per-bank load strobe to 74173 g1_n pin, active-low, registered.
- grant  output  NUM_REQ  one-hot current owner, registered; equals ~oe_n.
- bus_busy  output  1  high in GRANT or TURN.

Behaviour:
- Reset (clr_n low, async):
  - oe_n = all 1, ld_n = all 1, grant = 0, bus_busy = 0.
  - state = IDLE; rr pointer = NUM_REQ-1, so bank 0 has first priority.
  - Hold and grant counters cleared.
- Reset asserted mid-grant drops oe_n high immediately, without waiting for clk.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr+1 (wrapping mod NUM_REQ).
  - Next edge: grant/oe_n assert for that bank, rr = winner, counter = 1, state = GRANT.
  - Latency: req high at edge k in IDLE gives oe_n low after edge k+1.
  - No req: stay in IDLE, all outputs idle.
- GRANT:
  - counter increments each cycle, saturating at MAX_GRANT.
  - Release when req[owner] = 0 and counter >= MIN_HOLD: next edge deasserts oe_n/grant, state = TURN.
  - If req[owner] drops before MIN_HOLD, keep the grant until counter reaches MIN_HOLD, then release.
  - Preempt when MAX_GRANT != 0, counter == MAX_GRANT, and any other req bit is set: release as above, regardless of req[owner].
  - With no other requester pending, the owner keeps the bus indefinitely.
- TURN:
  - All oe_n high for exactly TURNAROUND cycles, then IDLE.
  - Arbitration happens in IDLE, so the gap between two owners is TURNAROUND+1 cycles, with no oe_n low in between.
- A requester still asserting req after release is re-eligible; round-robin order guarantees others get served first.
- Loads:
  - ld_req[i] high at an edge gives ld_n[i] low for exactly the next cycle, then high.
  - A continuously high ld_req[i] produces a pulse every cycle (level follow).
  - Loads are independent of the bus state machine.
  - Multiple banks may load in the same cycle.
  - Loading the current owner is allowed; the bus shows new data one cycle after the ld_n pulse, per 74173 timing.
- Invariants:
  - popcount(~oe_n) <= 1 at all times.
  - grant == ~oe_n.
  - bus_busy == (state != IDLE).
- Width rules: counters sized to ceil(log2(max(MIN_HOLD, MAX_GRANT, TURNAROUND)+1)). rr pointer is ceil(log2(NUM_REQ)) bits and wraps modulo NUM_REQ.

Test Plan:
- Reset, then req=4'b0001 held 5 cycles and dropped → oe_n=4'b1110 from cycle 1 through the cycle after req drops, then 4'b1111 for 1 TURN cycle, bus_busy tracks.
- req=4'b1111 constant, MAX_GRANT=16 → grant sequence 0001, 0010, 0100, 1000, 0001, each 16 cycles long, separated by 2 all-idle cycles; never two bits low in oe_n.
- req[2] pulsed high for 1 cycle only, MIN_HOLD=2 → oe_n[2] low for exactly 2 cycles, then TURN.
- Owner bank 1 holding with MAX_GRANT=0 while req[3] is asserted → bank 1 keeps the bus indefinitely; bank 3 is granted 2 cycles after req[1] drops.
- ld_req=4'b0101 for 1 cycle during grant of bank 0 → ld_n=4'b1010 for exactly one cycle, grant unaffected.
- clr_n pulled low mid-GRANT, between clock edges → oe_n=4'b1111 immediately; after release, req=4'b1000 goes to bank 3, and subsequent req=4'b1001 goes to bank 0 first.
